// File: rtl/ps2_kbd_rx_pkg.sv
// Shared PS/2 definitions: prefix byte values, receive FSM encoding, parity helper.
package ps2_kbd_rx_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Odd parity holds when byte plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter; idles high.
module ps2_line_filter
  import ps2_kbd_rx_pkg::*;
#(
  parameter int unsigned C_FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic line_o
);

  localparam int unsigned CNT_W = $clog2(C_FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_FILTER_LEN - 1);

  logic [1:0]       sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive synced samples that disagree with the filtered value.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, filter output and run counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes device-to-host bytes and folds E0/F0 prefixes into flags.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int unsigned C_FILTER_LEN = 8,
  parameter int unsigned C_TIMEOUT    = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       extended,
  output logic       released,
  output logic [7:0] last_code,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int unsigned TO_W = $clog2(C_TIMEOUT);
  // Counter holds clks elapsed since the last fall event; the abort strobe
  // lands in the cycle the elapsed count reaches C_TIMEOUT-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(C_TIMEOUT - 2);

  logic ps2clk_f, ps2data_f;
  logic clk_prev_q;
  logic fall_c;
  logic par_ok_c;

  ps2_state_e      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;

  logic [7:0] code_q, code_d;
  logic       code_valid_q, code_valid_d;
  logic       extended_q, extended_d;
  logic       released_q, released_d;
  logic [7:0] last_code_q, last_code_d;
  logic       err_parity_q, err_parity_d;
  logic       err_frame_q, err_frame_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;

  ps2_line_filter #(.C_FILTER_LEN(C_FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2clk_i),
    .line_o (ps2clk_f)
  );

  ps2_line_filter #(.C_FILTER_LEN(C_FILTER_LEN)) u_data_filt (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2data_i),
    .line_o (ps2data_f)
  );

  assign fall_c   = clk_prev_q & ~ps2clk_f;
  assign par_ok_c = odd_parity_ok(shift_q, par_q);

  // Frame FSM, timeout, prefix folding and output strobes.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_d         = to_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    extended_d   = extended_q;
    released_d   = released_q;
    last_code_d  = last_code_q;
    err_parity_d = 1'b0;
    err_frame_d  = 1'b0;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;

    case (state_q)
      ST_IDLE: begin
        to_d = '0;
        if (fall_c && !ps2data_f) begin
          state_d  = ST_DATA;
          bitcnt_d = 3'd0;
          to_d     = TO_W'(1);
        end
      end
      ST_DATA: begin
        if (fall_c) begin
          shift_d  = {ps2data_f, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          to_d     = TO_W'(1);
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall_c) begin
          par_d   = ps2data_f;
          state_d = ST_STOP;
          to_d    = TO_W'(1);
        end
      end
      ST_STOP: begin
        if (fall_c) begin
          state_d = ST_IDLE;
          to_d    = '0;
          if (!par_ok_c || !ps2data_f) begin
            err_parity_d = ~par_ok_c;
            err_frame_d  = ~ps2data_f;
            ext_pend_d   = 1'b0;
            brk_pend_d   = 1'b0;
          end else if (shift_q == PS2_EXT) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == PS2_BRK) begin
            brk_pend_d = 1'b1;
          end else begin
            code_d       = shift_q;
            extended_d   = ext_pend_q;
            released_d   = brk_pend_q;
            code_valid_d = 1'b1;
            ext_pend_d   = 1'b0;
            brk_pend_d   = 1'b0;
            if (!brk_pend_q) begin
              last_code_d = shift_q;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        to_d    = '0;
      end
    endcase

    // A fall event in the same cycle always takes precedence over the abort.
    if (state_q != ST_IDLE && !fall_c) begin
      if (to_q == TO_LAST) begin
        state_d     = ST_IDLE;
        to_d        = '0;
        err_frame_d = 1'b1;
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      to_q         <= '0;
      code_q       <= 8'd0;
      code_valid_q <= 1'b0;
      extended_q   <= 1'b0;
      released_q   <= 1'b0;
      last_code_q  <= 8'd0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
    end else begin
      clk_prev_q   <= ps2clk_f;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_q         <= to_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      extended_q   <= extended_d;
      released_q   <= released_d;
      last_code_q  <= last_code_d;
      err_parity_q <= err_parity_d;
      err_frame_q  <= err_frame_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign extended   = extended_q;
  assign released   = released_q;
  assign last_code  = last_code_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: PS/2 device model, frame-level reference model, per-cycle compare.
module tb_ps2_kbd_rx;

  localparam int unsigned FILT = 8;
  localparam int unsigned TO   = 300;
  localparam int          H    = 40;   // PS/2 half period in clk cycles
  localparam int          LAT_FALL = 10; // raw pin edge -> filtered fall event (2 sync + FILT)

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2clk, ps2data;
  logic [7:0] code, last_code;
  logic       code_valid, extended, released, err_parity, err_frame;

  ps2_kbd_rx #(.C_FILTER_LEN(FILT), .C_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2clk_i   (ps2clk),
    .ps2data_i  (ps2data),
    .code       (code),
    .code_valid (code_valid),
    .extended   (extended),
    .released   (released),
    .last_code  (last_code),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected output events, keyed by the cycle they must be visible.
  typedef struct {
    int         at;
    bit         cv, ep, ef;
    logic [7:0] code;
    bit         ext, rel;
    logic [7:0] lc;
  } ev_t;
  ev_t evq[$];

  // Frame-level reference state.
  bit         m_ext, m_brk;
  logic [7:0] m_code, m_lc;

  function automatic void model_byte(input logic [7:0] b, input bit p, input bit stop, input int at);
    ev_t e;
    e.at = at; e.cv = 0; e.ext = 0; e.rel = 0;
    e.ep = ((^b) ^ p) == 1'b0;
    e.ef = !stop;
    if (e.ep || e.ef) begin
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1; return;
    end else if (b == 8'hF0) begin
      m_brk = 1; return;
    end else begin
      e.cv = 1; e.ext = m_ext; e.rel = m_brk;
      m_code = b;
      if (!m_brk) m_lc = b;
      m_ext = 0; m_brk = 0;
    end
    e.code = m_code; e.lc = m_lc;
    evq.push_back(e);
  endfunction

  function automatic void model_timeout(input int at);
    ev_t e;
    e.at = at; e.cv = 0; e.ep = 0; e.ef = 1; e.ext = 0; e.rel = 0;
    m_ext = 0; m_brk = 0;
    e.code = m_code; e.lc = m_lc;
    evq.push_back(e);
  endfunction

  // Observations from the compare process, used by literal checks.
  logic [7:0] cur_code = 8'd0, cur_lc = 8'd0;
  int last_cv_at = -1, last_ef_at = -1, n_cv = 0, n_ep = 0, n_ef = 0;
  bit cv_ext, cv_rel;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    ev_t e;
    bit  x_cv, x_ep, x_ef;
    x_cv = 0; x_ep = 0; x_ef = 0;
    if (reset) begin
      cur_code = 8'd0; cur_lc = 8'd0;
      chk("rst_code_valid", code_valid, 0);
      chk("rst_err_parity", err_parity, 0);
      chk("rst_err_frame", err_frame, 0);
      chk("rst_code", code, 0);
      chk("rst_last_code", last_code, 0);
      chk("rst_extended", extended, 0);
      chk("rst_released", released, 0);
    end else begin
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        x_cv = e.cv; x_ep = e.ep; x_ef = e.ef;
        cur_code = e.code; cur_lc = e.lc;
        if (e.cv) begin
          chk("extended", extended, e.ext);
          chk("released", released, e.rel);
        end
      end
      chk("code_valid", code_valid, x_cv);
      chk("err_parity", err_parity, x_ep);
      chk("err_frame", err_frame, x_ef);
      chk("code", code, cur_code);
      chk("last_code", last_code, cur_lc);
      if (code_valid) begin last_cv_at = cyc; n_cv++; cv_ext = extended; cv_rel = released; end
      if (err_parity) n_ep++;
      if (err_frame) begin last_ef_at = cyc; n_ef++; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fall_at;

  // One PS/2 bit: data changes mid-high, then clock low for a half period.
  task automatic send_bit(input logic d, input bit glitch);
    if (glitch) begin
      tick(4); ps2clk = 1'b0; tick(5); ps2clk = 1'b1; tick(H/2 - 9);
    end else begin
      tick(H/2);
    end
    ps2data = d;
    tick(H/2);
    ps2clk = 1'b0;
    fall_at = cyc;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit p, input bit stop, input bit glitch);
    logic [10:0] fr;
    fr = {stop, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      send_bit(fr[i], glitch);
      if (i == 10) model_byte(b, p, stop, fall_at + LAT_FALL + 1);
      tick(H);
      ps2clk = 1'b1;
    end
    tick(H/2);
    ps2data = 1'b1;
    tick(H);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~(^b), 1'b1, 1'b0);
  endtask

  // Start bit plus nbits-1 data bits, then the clock stays high.
  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [8:0] fr;
    fr = {b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(fr[i], 1'b0);
      tick(H);
      ps2clk = 1'b1;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish want finish by 600000");
    $fatal(1, "watchdog");
  end

  initial begin
    int cv0;
    reset = 1'b1; ps2clk = 1'b1; ps2data = 1'b1;
    m_ext = 0; m_brk = 0; m_code = 8'd0; m_lc = 8'd0;
    tick(5);
    reset = 1'b0;
    tick(20);

    // 1: plain make code
    send_good(8'h1C);
    chk("t1_code", code, 8'h1C);
    chk("t1_last_code", last_code, 8'h1C);
    chk("t1_latency", last_cv_at - fall_at, 11);
    chk("t1_ext_rel", {cv_ext, cv_rel}, 2'b00);

    // 2: break code
    cv0 = n_cv;
    send_good(8'hF0);
    send_good(8'h1C);
    chk("t2_one_strobe", n_cv - cv0, 1);
    chk("t2_released", cv_rel, 1);
    chk("t2_extended", cv_ext, 0);
    chk("t2_last_code", last_code, 8'h1C);

    // 3: extended break, then plain make
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    chk("t3_code", code, 8'h75);
    chk("t3_ext_rel", {cv_ext, cv_rel}, 2'b11);
    send_good(8'h74);
    chk("t3_ext_rel2", {cv_ext, cv_rel}, 2'b00);
    chk("t3_last_code", last_code, 8'h74);

    // 4: parity error, stop error, pends cleared
    cv0 = n_cv;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("t4_parity_err", n_ep, 1);
    send_good(8'hF0);
    send_frame(8'h2A, ~(^8'h2A), 1'b0, 1'b0);
    chk("t4_frame_err", n_ef, 1);
    chk("t4_no_strobe", n_cv - cv0, 0);
    send_good(8'h2A);
    chk("t4_code", code, 8'h2A);
    chk("t4_released", cv_rel, 0);

    // 5: timeout after four fall events
    send_partial(8'h29, 4);
    model_timeout(fall_at + LAT_FALL + TO - 1);
    tick(TO + 40);
    chk("t5_timeout_at", last_ef_at - fall_at, LAT_FALL + TO - 1);
    chk("t5_frame_err", n_ef, 2);
    send_good(8'h29);
    chk("t5_code", code, 8'h29);
    chk("t5_last_code", last_code, 8'h29);

    // 6: glitches on the clock line, then reset mid-frame
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    chk("t6_glitch_code", code, 8'h1C);
    send_partial(8'h55, 5);
    reset = 1'b1;
    evq.delete();
    m_ext = 0; m_brk = 0; m_code = 8'd0; m_lc = 8'd0;
    tick(3);
    reset = 1'b0;
    tick(20);
    chk("t6_code_zero", code, 8'h00);
    chk("t6_last_zero", last_code, 8'h00);
    send_good(8'h1C);
    chk("t6_code", code, 8'h1C);
    chk("t6_last_code", last_code, 8'h1C);

    tick(10);
    chk("queue_drained", evq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
